// File: rtl/restoring_divider.sv
// Sequential radix-2 restoring divider for the calculator ALU: one iteration per clock,
// fixed 18-cycle latency from acceptance to the one-cycle alu_done pulse.
module restoring_divider #(
    parameter int         WIDTH  = 16,
    parameter logic [4:0] OP_DIV = 5'h04
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [3:0]           dtype,
    input  logic [4:0]           operator,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    input  logic                 parser_done,
    output logic [2*WIDTH-1:0]   calc_res,
    output logic                 alu_done,
    output logic                 div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_r;
    logic             signed_r;
    logic             neg1_r;
    logic             neg2_r;
    logic             zero_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] src1_r;
    logic [WIDTH:0]   r_r;
    logic [4:0]       cnt_r;

    logic             is_signed_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] quot_s;
    logic [WIDTH-1:0] rem_s;

    // Two's-complement magnitude; the most negative value maps to itself read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        if (sgn && x[WIDTH-1]) begin
            magnitude = -x;
        end else begin
            magnitude = x;
        end
    endfunction

    // Trial subtraction and sign correction of the final quotient/remainder.
    always_comb begin
        is_signed_s = (dtype == 4'h1);
        trial_s     = {r_r[WIDTH-1:0], q_r[WIDTH-1]} - {1'b0, d_r};
        if (signed_r && (neg1_r != neg2_r)) begin
            quot_s = -q_r;
        end else begin
            quot_s = q_r;
        end
        if (signed_r && neg1_r) begin
            rem_s = -r_r[WIDTH-1:0];
        end else begin
            rem_s = r_r[WIDTH-1:0];
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_r  <= IDLE;
            signed_r <= 1'b0;
            neg1_r   <= 1'b0;
            neg2_r   <= 1'b0;
            zero_r   <= 1'b0;
            q_r      <= '0;
            d_r      <= '0;
            src1_r   <= '0;
            r_r      <= '0;
            cnt_r    <= 5'd0;
            calc_res <= '0;
            div_zero <= 1'b0;
            alu_done <= 1'b0;
        end else begin
            alu_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (parser_done && (operator == OP_DIV)) begin
                        signed_r <= is_signed_s;
                        neg1_r   <= is_signed_s & src1[WIDTH-1];
                        neg2_r   <= is_signed_s & src2[WIDTH-1];
                        q_r      <= magnitude(src1, is_signed_s);
                        d_r      <= magnitude(src2, is_signed_s);
                        src1_r   <= src1;
                        r_r      <= '0;
                        cnt_r    <= 5'd0;
                        zero_r   <= (src2 == '0);
                        state_r  <= CALC;
                    end
                end
                CALC: begin
                    // Restore by simply not committing a negative trial result.
                    if (!trial_s[WIDTH]) begin
                        r_r <= trial_s;
                        q_r <= {q_r[WIDTH-2:0], 1'b1};
                    end else begin
                        r_r <= {r_r[WIDTH-1:0], q_r[WIDTH-1]};
                        q_r <= {q_r[WIDTH-2:0], 1'b0};
                    end
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == 5'(WIDTH - 1)) begin
                        state_r <= FIX;
                    end
                end
                FIX: begin
                    if (zero_r) begin
                        calc_res <= {src1_r, {WIDTH{1'b1}}};
                        div_zero <= 1'b1;
                    end else begin
                        calc_res <= {rem_s, quot_s};
                        div_zero <= 1'b0;
                    end
                    alu_done <= 1'b1;
                    state_r  <= DONE;
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed corner cases plus randomized
// divides compared against a plain-arithmetic reference model.
module tb_restoring_divider;

    localparam logic [4:0] OP_DIV = 5'h04;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [3:0]  dtype;
    logic [4:0]  operator;
    logic [15:0] src1;
    logic [15:0] src2;
    logic        parser_done;
    logic [31:0] calc_res;
    logic        alu_done;
    logic        div_zero;

    int n_cmp = 0;
    int n_bad = 0;

    restoring_divider dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .dtype       (dtype),
        .operator    (operator),
        .src1        (src1),
        .src2        (src2),
        .parser_done (parser_done),
        .calc_res    (calc_res),
        .alu_done    (alu_done),
        .div_zero    (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {div_zero, remainder, quotient} from integer arithmetic.
    function automatic logic [32:0] model(input logic [3:0] dt, input logic [15:0] a, input logic [15:0] b);
        int          sa;
        int          sb;
        int          q;
        int          r;
        logic [31:0] qv;
        logic [31:0] rv;
        if (b == 16'd0) begin
            return {1'b1, a, 16'hFFFF};
        end
        if (dt == 4'h1) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
        end else begin
            sa = int'({16'd0, a});
            sb = int'({16'd0, b});
        end
        q  = sa / sb;
        r  = sa % sb;
        qv = 32'(q);
        rv = 32'(r);
        return {1'b0, rv[15:0], qv[15:0]};
    endfunction

    logic [31:0] last_res = 32'h0;

    // One divide; optionally re-pulses parser_done at edge E<inject_at> with junk operands.
    task automatic run_div(input string tag, input logic [3:0] dt, input logic [15:0] a,
                           input logic [15:0] b, input int inject_at);
        logic [32:0] e;
        int          c;
        bit          seen;
        e = model(dt, a, b);
        @(negedge clk);
        dtype = dt; operator = OP_DIV; src1 = a; src2 = b; parser_done = 1'b1;
        @(negedge clk);
        parser_done = 1'b0;
        src1 = 16'($urandom); src2 = 16'($urandom);
        dtype = 4'($urandom); operator = 5'($urandom);
        c = 1;
        seen = 1'b0;
        while (!seen && c <= 40) begin
            if (alu_done) begin
                seen = 1'b1;
            end else begin
                if (c == inject_at) begin
                    operator = OP_DIV; dtype = 4'h1; parser_done = 1'b1;
                end else begin
                    parser_done = 1'b0;
                end
                @(negedge clk);
                c++;
            end
        end
        parser_done = 1'b0;
        chk({tag, " latency"}, seen ? 32'(c) : 32'hFFFF_FFFF, 32'd18);
        if (seen) begin
            chk({tag, " calc_res"}, calc_res, e[31:0]);
            chk({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, e[32]});
            last_res = e[31:0];
            @(negedge clk);
            chk({tag, " pulse width"}, {31'd0, alu_done}, 32'd0);
        end
    endtask

    int hits;

    initial begin
        n_rst = 1'b1; dtype = 4'h0; operator = 5'h00; src1 = 16'h0; src2 = 16'h0; parser_done = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b0;
        chk("reset calc_res", calc_res, 32'h0);
        chk("reset div_zero", {31'd0, div_zero}, 32'd0);
        chk("reset alu_done", {31'd0, alu_done}, 32'd0);

        run_div("u100/7", 4'h0, 16'd100, 16'd7, 0);
        chk("u100/7 const", last_res, 32'h0002000E);
        run_div("s-7/2", 4'h1, 16'hFFF9, 16'h0002, 0);
        chk("s-7/2 const", calc_res, 32'hFFFFFFFD);
        run_div("s7/-2", 4'h1, 16'h0007, 16'hFFFE, 0);
        chk("s7/-2 const", calc_res, 32'h0001FFFD);
        run_div("divzero", 4'h0, 16'h1234, 16'h0000, 0);
        chk("divzero const", calc_res, 32'h1234FFFF);
        run_div("u9/3", 4'h0, 16'd9, 16'd3, 0);
        chk("u9/3 const", calc_res, 32'h00000003);
        run_div("s-32768/-1", 4'h1, 16'h8000, 16'hFFFF, 0);
        chk("overflow const", calc_res, 32'h00008000);
        run_div("uFFFF/1", 4'h0, 16'hFFFF, 16'h0001, 0);
        chk("uFFFF/1 const", calc_res, 32'h0000FFFF);
        run_div("s-sdivzero", 4'h1, 16'h8001, 16'h0000, 0);
        run_div("inject", 4'h0, 16'd1000, 16'd33, 5);

        // Foreign operator must not start the block.
        @(negedge clk);
        operator = 5'h03; dtype = 4'h0; src1 = 16'd77; src2 = 16'd5; parser_done = 1'b1;
        @(negedge clk);
        parser_done = 1'b0;
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            if (alu_done) hits++;
            @(negedge clk);
        end
        chk("badop alu_done", 32'(hits), 32'd0);
        chk("badop calc_res hold", calc_res, last_res);

        // Reset at E8 discards the in-flight divide.
        @(negedge clk);
        operator = OP_DIV; dtype = 4'h0; src1 = 16'd1000; src2 = 16'd3; parser_done = 1'b1;
        @(negedge clk);
        parser_done = 1'b0;
        repeat (7) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        n_rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            if (alu_done) hits++;
            @(negedge clk);
        end
        chk("midreset alu_done", 32'(hits), 32'd0);
        chk("midreset calc_res", calc_res, 32'h0);
        chk("midreset div_zero", {31'd0, div_zero}, 32'd0);
        run_div("u50/5", 4'h0, 16'd50, 16'd5, 0);
        chk("u50/5 const", calc_res, 32'h0000000A);

        for (int k = 0; k < 150; k++) begin
            logic [3:0]  dt;
            logic [15:0] a;
            logic [15:0] b;
            case ($urandom_range(0, 2))
                0:       dt = 4'h0;
                1:       dt = 4'h1;
                default: dt = 4'($urandom);
            endcase
            a = 16'($urandom);
            case ($urandom_range(0, 9))
                0:       b = 16'h0000;
                1:       b = 16'($urandom_range(1, 15));
                2:       b = 16'hFFFF;
                default: b = 16'($urandom);
            endcase
            run_div("random", dt, a, b, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
